// File: rtl/ram_bus_master.sv
// ram_bus_master
//   Single initiator for the synchronous single-port RAM bus (addr / bidirectional data /
//   cs / we / oe). Takes one read or write request at a time on a valid/ready port,
//   sequences the RAM pins and returns read data or a write acknowledge on a one-cycle
//   response pulse. It is the only driver of the RAM bus.
//
//   Optional feature macro: RAM_MASTER_WRITE_VERIFY_EN
//     defined   : every write is followed by a bus-idle gap cycle and a full read of the
//                 same address; the write response carries rsp_err=1 on readback mismatch.
//     undefined : no verify states; rsp_err is constant 0.
//
// Ports
//   clk        in   1           system clock, rising edge
//   rst        in   1           asynchronous active-high reset
//   req_valid  in   1           request present
//   req_ready  out  1           idle; request accepted when req_valid && req_ready
//   req_we     in   1           1 = write, 0 = read
//   req_addr   in   ADDR_WIDTH  target address
//   req_wdata  in   DATA_WIDTH  write data
//   rsp_valid  out  1           one-cycle response pulse
//   rsp_we     out  1           req_we of the request being answered
//   rsp_rdata  out  DATA_WIDTH  read data, holds between read responses
//   rsp_err    out  1           write-verify mismatch
//   mem_addr   out  ADDR_WIDTH  RAM address, holds in idle
//   mem_data   io   DATA_WIDTH  RAM data, driven only while writing
//   mem_cs     out  1           RAM chip select
//   mem_we     out  1           RAM write enable
//   mem_oe     out  1           RAM output enable
module ram_bus_master #(
  parameter int ADDR_WIDTH   = 16,
  parameter int DATA_WIDTH   = 8,
  parameter int READ_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  output logic                  rsp_we,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  inout  wire  [DATA_WIDTH-1:0] mem_data,
  output logic                  mem_cs,
  output logic                  mem_we,
  output logic                  mem_oe
);

  // Read phase lasts READ_LATENCY+1 cycles; the counter runs 0..READ_LATENCY.
  localparam int CNT_W = (READ_LATENCY < 1) ? 1 : $clog2(READ_LATENCY + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(READ_LATENCY);

`ifdef RAM_MASTER_WRITE_VERIFY_EN
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WR   = 3'd1,
    ST_RD   = 3'd2,
    ST_GAP  = 3'd3,
    ST_VRD  = 3'd4
  } state_t;

  // Readback compare for the write-verify pass.
  function automatic logic verify_mismatch(input logic [DATA_WIDTH-1:0] readback,
                                           input logic [DATA_WIDTH-1:0] expected);
    return (readback != expected);
  endfunction
`else
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WR   = 2'd1,
    ST_RD   = 2'd2
  } state_t;
`endif

  state_t                  state_r;
  state_t                  next_state_s;
  logic [CNT_W-1:0]        cnt_r;
  logic                    in_rd_s;
  logic                    last_s;
  logic                    accept_s;

  logic                    cs_nxt_s;
  logic                    we_nxt_s;
  logic                    oe_nxt_s;
  logic                    rsp_valid_nxt_s;
  logic                    rsp_we_nxt_s;
  logic                    rd_capture_s;
  logic                    vrd_capture_s;

  logic                    req_ready_r;
  logic                    rsp_valid_r;
  logic                    rsp_we_r;
  logic [DATA_WIDTH-1:0]   rsp_rdata_r;
  logic [ADDR_WIDTH-1:0]   mem_addr_r;
  logic [DATA_WIDTH-1:0]   wdata_r;
  logic                    mem_cs_r;
  logic                    mem_we_r;
  logic                    mem_oe_r;
  logic                    drive_r;

`ifdef RAM_MASTER_WRITE_VERIFY_EN
  assign in_rd_s = (state_r == ST_RD) || (state_r == ST_VRD);
`else
  assign in_rd_s = (state_r == ST_RD);
`endif
  assign last_s   = in_rd_s && (cnt_r == CNT_LAST);
  assign accept_s = req_valid && (state_r == ST_IDLE);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (req_valid) begin
          next_state_s = req_we ? ST_WR : ST_RD;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
`ifdef RAM_MASTER_WRITE_VERIFY_EN
      ST_WR:   next_state_s = ST_GAP;
      ST_GAP:  next_state_s = ST_VRD;
      ST_VRD: begin
        if (last_s) begin
          next_state_s = ST_IDLE;
        end else begin
          next_state_s = ST_VRD;
        end
      end
`else
      ST_WR:   next_state_s = ST_IDLE;
`endif
      ST_RD: begin
        if (last_s) begin
          next_state_s = ST_IDLE;
        end else begin
          next_state_s = ST_RD;
        end
      end
      default: next_state_s = ST_IDLE;
    endcase
  end

  // Output decode: pin values for the coming cycle and response events at this edge.
  always_comb begin
    cs_nxt_s        = 1'b0;
    we_nxt_s        = 1'b0;
    oe_nxt_s        = 1'b0;
    rsp_valid_nxt_s = 1'b0;
    rsp_we_nxt_s    = 1'b0;
    rd_capture_s    = 1'b0;
    vrd_capture_s   = 1'b0;

    // Pins follow the state being entered so they are registered yet cycle-aligned.
    case (next_state_s)
      ST_WR: begin
        cs_nxt_s = 1'b1;
        we_nxt_s = 1'b1;
      end
      ST_RD: begin
        cs_nxt_s = 1'b1;
        oe_nxt_s = 1'b1;
      end
`ifdef RAM_MASTER_WRITE_VERIFY_EN
      ST_VRD: begin
        cs_nxt_s = 1'b1;
        oe_nxt_s = 1'b1;
      end
`endif
      default: begin
        cs_nxt_s = 1'b0;
        we_nxt_s = 1'b0;
        oe_nxt_s = 1'b0;
      end
    endcase

    case (state_r)
`ifndef RAM_MASTER_WRITE_VERIFY_EN
      ST_WR: begin
        rsp_valid_nxt_s = 1'b1;
        rsp_we_nxt_s    = 1'b1;
      end
`endif
      ST_RD: begin
        if (last_s) begin
          rsp_valid_nxt_s = 1'b1;
          rd_capture_s    = 1'b1;
        end else begin
          rsp_valid_nxt_s = 1'b0;
          rd_capture_s    = 1'b0;
        end
      end
`ifdef RAM_MASTER_WRITE_VERIFY_EN
      ST_VRD: begin
        if (last_s) begin
          rsp_valid_nxt_s = 1'b1;
          rsp_we_nxt_s    = 1'b1;
          vrd_capture_s   = 1'b1;
        end else begin
          rsp_valid_nxt_s = 1'b0;
          rsp_we_nxt_s    = 1'b0;
          vrd_capture_s   = 1'b0;
        end
      end
`endif
      default: begin
        rsp_valid_nxt_s = 1'b0;
        rsp_we_nxt_s    = 1'b0;
      end
    endcase
  end

  // Read-phase cycle counter; rests at zero outside read states.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (in_rd_s && !last_s) begin
      cnt_r <= cnt_r + CNT_W'(1);
    end else begin
      cnt_r <= {CNT_W{1'b0}};
    end
  end

  // RAM pin and request-latch registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_ready_r <= 1'b1;
      mem_cs_r    <= 1'b0;
      mem_we_r    <= 1'b0;
      mem_oe_r    <= 1'b0;
      drive_r     <= 1'b0;
      mem_addr_r  <= {ADDR_WIDTH{1'b0}};
      wdata_r     <= {DATA_WIDTH{1'b0}};
    end else begin
      req_ready_r <= (next_state_s == ST_IDLE);
      mem_cs_r    <= cs_nxt_s;
      mem_we_r    <= we_nxt_s;
      mem_oe_r    <= oe_nxt_s;
      // Data is driven exactly when write-enable is, never alongside oe.
      drive_r     <= we_nxt_s;
      if (accept_s) begin
        mem_addr_r <= req_addr;
        wdata_r    <= req_wdata;
      end
    end
  end

  // Response registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid_r <= 1'b0;
      rsp_we_r    <= 1'b0;
      rsp_rdata_r <= {DATA_WIDTH{1'b0}};
    end else begin
      rsp_valid_r <= rsp_valid_nxt_s;
      if (rsp_valid_nxt_s) begin
        rsp_we_r <= rsp_we_nxt_s;
      end
      if (rd_capture_s) begin
        rsp_rdata_r <= mem_data;
      end
    end
  end

`ifdef RAM_MASTER_WRITE_VERIFY_EN
  logic rsp_err_r;

  // Verify result register; updated with every response, 0 for plain reads.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_err_r <= 1'b0;
    end else if (rsp_valid_nxt_s) begin
      rsp_err_r <= vrd_capture_s ? verify_mismatch(mem_data, wdata_r) : 1'b0;
    end
  end

  assign rsp_err = rsp_err_r;
`else
  assign rsp_err = 1'b0;
`endif

  assign req_ready = req_ready_r;
  assign rsp_valid = rsp_valid_r;
  assign rsp_we    = rsp_we_r;
  assign rsp_rdata = rsp_rdata_r;
  assign mem_addr  = mem_addr_r;
  assign mem_cs    = mem_cs_r;
  assign mem_we    = mem_we_r;
  assign mem_oe    = mem_oe_r;
  assign mem_data  = drive_r ? wdata_r : {DATA_WIDTH{1'bz}};

endmodule

// File: tb/tb_ram_bus_master.sv
module tb_ram_bus_master;

  localparam int AW = 16;
  localparam int DW = 8;
  localparam int L  = 1;
`ifdef RAM_MASTER_WRITE_VERIFY_EN
  localparam int WR_LAT = 4 + L;
`else
  localparam int WR_LAT = 2;
`endif
  localparam int RD_LAT = 2 + L;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          rsp_valid;
  logic          rsp_we;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic [AW-1:0] mem_addr;
  wire  [DW-1:0] mem_data;
  logic          mem_cs;
  logic          mem_we;
  logic          mem_oe;

  ram_bus_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_LATENCY(L)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_we(rsp_we), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_addr(mem_addr), .mem_data(mem_data),
    .mem_cs(mem_cs), .mem_we(mem_we), .mem_oe(mem_oe)
  );

  always #5 clk = ~clk;

  // Synchronous RAM model, read latency L, output gated by oe; optional bit0 stuck at 0.
  bit [DW-1:0]   ram [0:65535];
  bit [DW-1:0]   rd_pipe [0:L-1];
  logic [L-1:0]  rd_vld = '0;
  logic          stuck_bit0 = 1'b0;

  always @(posedge clk) begin
    if (mem_cs && mem_we) ram[mem_addr] <= stuck_bit0 ? (mem_data & 8'hFE) : mem_data;
    rd_pipe[0] <= ram[mem_addr];
    rd_vld[0]  <= mem_cs && mem_oe && !mem_we;
    for (int i = 1; i < L; i++) begin
      rd_pipe[i] <= rd_pipe[i-1];
      rd_vld[i]  <= rd_vld[i-1];
    end
  end

  assign mem_data = (rd_vld[L-1] && mem_oe) ? rd_pipe[L-1] : {DW{1'bz}};

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Cycle counter and bus-rule monitor, sampled at the rising edge (pre-update values).
  int   cyc = 0;
  int   cs_starts = 0;
  int   viol = 0;
  logic prev_cs = 1'b0, prev_oe = 1'b0, prev_we = 1'b0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    prev_cs <= mem_cs;
    prev_oe <= mem_oe;
    prev_we <= mem_we;
    if (!rst) begin
      if (mem_cs && !prev_cs) cs_starts <= cs_starts + 1;
      if ((mem_oe && mem_we) || (mem_we && prev_oe) || (mem_oe && prev_we)) viol <= viol + 1;
    end
  end

  // Scoreboard of expected responses.
  typedef struct {
    logic          we;
    logic [DW-1:0] rdata;
    logic          err;
    int            due;
  } exp_t;
  exp_t sbq[$];
  logic [DW-1:0] last_rd = '0;

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      last_rd <= '0;
      sbq.delete();
    end else if (rsp_valid) begin
      if (sbq.size() == 0) begin
        check("unexpected_rsp", 32'd1, 32'd0);
      end else begin
        e = sbq.pop_front();
        check("rsp_cycle", cyc, e.due);
        check("rsp_we", rsp_we, e.we);
        if (!e.we) begin
          check("rsp_rdata", rsp_rdata, e.rdata);
          last_rd <= e.rdata;
        end else begin
          check("rdata_hold", rsp_rdata, last_rd);
        end
        check("rsp_err", rsp_err, e.err);
      end
    end
  end

  task automatic push_exp(input logic we, input logic [DW-1:0] rdata, input logic err);
    exp_t e;
    e.we = we; e.rdata = rdata; e.err = err;
    e.due = cyc + (we ? WR_LAT : RD_LAT);
    sbq.push_back(e);
  endtask

  // Present a request at a falling edge and wait for it to be accepted.
  // Returns at the falling edge of the first cycle after acceptance.
  task automatic send(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                      input logic [DW-1:0] exp_rdata, input logic exp_err, input logic release_valid);
    int n;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata;
    n = 0;
    while (!req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      check("accept_timeout", 32'd0, 32'd1);
      req_valid = 1'b0;
    end else begin
      push_exp(we, exp_rdata, exp_err);
      @(negedge clk);
      if (release_valid) req_valid = 1'b0;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sbq.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("drain", sbq.size(), 32'd0);
  endtask

  task automatic check_rst(input string tag);
    check({tag, "_ctrl"}, {req_ready, rsp_valid, rsp_we, rsp_err, mem_cs, mem_we, mem_oe}, 7'b1000000);
    check({tag, "_addr"}, mem_addr, 32'd0);
    check({tag, "_rdata"}, rsp_rdata, 32'd0);
  endtask

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
  } vec_t;
  vec_t vecs[11];

  int cs0;

  initial begin
    vecs[0]  = '{1'b1, 16'h0000, 8'h33, 8'h00};
    vecs[1]  = '{1'b1, 16'hFFFF, 8'h55, 8'h00};
    vecs[2]  = '{1'b0, 16'hFFFF, 8'h00, 8'h55};
    vecs[3]  = '{1'b0, 16'h0000, 8'h00, 8'h33};
    vecs[4]  = '{1'b1, 16'h1234, 8'h5A, 8'h00};
    vecs[5]  = '{1'b1, 16'h1235, 8'hA5, 8'h00};
    vecs[6]  = '{1'b0, 16'h1234, 8'h00, 8'h5A};
    vecs[7]  = '{1'b0, 16'h1235, 8'h00, 8'hA5};
    vecs[8]  = '{1'b0, 16'h0001, 8'h00, 8'hAA};
    vecs[9]  = '{1'b1, 16'h0001, 8'hFF, 8'h00};
    vecs[10] = '{1'b0, 16'h0001, 8'h00, 8'hFF};

    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
    @(negedge clk);
    check_rst("por");
    @(negedge clk);
    rst = 1'b0;

    // Write 0x0001 <= 0xAA: pin values in the write cycle.
    send(1'b1, 16'h0001, 8'hAA, 8'h00, 1'b0, 1'b1);
    check("wr_pins", {mem_cs, mem_we, mem_oe}, 3'b110);
    check("wr_addr", mem_addr, 16'h0001);
    check("wr_data", mem_data, 8'hAA);
    drain();

    // Read 0x0001: read pins for L+1 cycles, RAM data appears in the last one.
    send(1'b0, 16'h0001, 8'h00, 8'hAA, 1'b0, 1'b1);
    check("rd_pins_n1", {mem_cs, mem_we, mem_oe}, 3'b101);
    check("rd_addr", mem_addr, 16'h0001);
    check("rd_ready_n1", req_ready, 1'b0);
    @(negedge clk);
    check("rd_pins_n2", {mem_cs, mem_we, mem_oe}, 3'b101);
    check("rd_bus_n2", mem_data, 8'hAA);
    drain();

    // Held request during a read: ignored until the response cycle, then accepted once.
    send(1'b0, 16'h0001, 8'h00, 8'hAA, 1'b0, 1'b0);
    cs0 = cs_starts;
    check("hold_ready_n1", req_ready, 1'b0);
    @(negedge clk);
    check("hold_ready_n2", req_ready, 1'b0);
    @(negedge clk);
    check("hold_ready_n3", req_ready, 1'b1);
    check("hold_rsp_n3", rsp_valid, 1'b1);
    check("hold_one_access", cs_starts - cs0, 32'd1);
    push_exp(1'b0, 8'hAA, 1'b0);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    check("hold_second_access", cs_starts - cs0, 32'd2);
    drain();

    // Table-driven back-to-back traffic, including the address extremes.
    for (int i = 0; i < 11; i++) begin
      send(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].rdata, 1'b0, 1'b1);
    end
    drain();

`ifdef RAM_MASTER_WRITE_VERIFY_EN
    // Write-verify against a RAM with bit0 stuck at 0.
    stuck_bit0 = 1'b1;
    send(1'b1, 16'h0010, 8'h01, 8'h00, 1'b1, 1'b1);
    send(1'b1, 16'h0011, 8'h02, 8'h00, 1'b0, 1'b1);
    send(1'b0, 16'h0010, 8'h00, 8'h00, 1'b0, 1'b1);
    drain();
    stuck_bit0 = 1'b0;
`endif

    // Reset in the middle of a read: immediate reset values, no response afterwards.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 16'h1234;
    @(posedge clk);
    #2;
    check("mid_in_txn", {mem_cs, mem_oe}, 2'b11);
    rst = 1'b1;
    req_valid = 1'b0;
    #1;
    check_rst("mid");
    @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    check("mid_idle_ready", req_ready, 1'b1);

    check("bus_rules", viol, 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
